// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared widths, parity-check masks and types for the Hamming(7,4) path
package hamming_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    // Each mask selects the codeword bits covered by one syndrome bit.
    localparam logic [CW_W-1:0] H0 = 7'b1010101;
    localparam logic [CW_W-1:0] H1 = 7'b1100110;
    localparam logic [CW_W-1:0] H2 = 7'b1111000;

    typedef logic [CW_W-1:0]  cw_t;
    typedef logic [SYN_W-1:0] syn_t;

endpackage

// File: rtl/hamming_syndrome.sv
// rtl/hamming_syndrome.sv - combinational syndrome and single-bit correction
// Ports:
//   cw_in  : received 7-bit word
//   syn    : syndrome, 0 = clean, else erroneous bit index + 1
//   cw_fix : word with the indicated bit inverted
//   err    : a bit was inverted
module hamming_syndrome
    import hamming_pkg::*;
(
    input  cw_t  cw_in,
    output syn_t syn,
    output cw_t  cw_fix,
    output logic err
);

    cw_t flip;

    assign syn = {^(cw_in & H2), ^(cw_in & H1), ^(cw_in & H0)};

    // Syndrome value k points at bit k-1; a zero syndrome selects nothing.
    always_comb begin
        flip = '0;
        for (int i = 0; i < CW_W; i++) begin
            flip[i] = (syn == SYN_W'(i + 1));
        end
    end

    assign cw_fix = cw_in ^ flip;
    assign err    = (syn != '0);

endmodule

// File: rtl/hamming_corrector.sv
// rtl/hamming_corrector.sv - streaming Hamming(7,4) single-error corrector with one output register
// Optional corrected-word counter enabled by macro HAMMING_ERR_COUNT_EN.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : input handshake, in_word received word
//   out_valid/out_ready    : output handshake
//   out_word/out_err/out_syn : corrected word, correction flag, syndrome
//   err_cnt/err_cnt_clr    : saturating corrected-word count and its clear (HAMMING_ERR_COUNT_EN)
module hamming_corrector
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW_W-1:0]  in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW_W-1:0]  out_word,
    output logic             out_err,
    output logic [SYN_W-1:0] out_syn
`ifdef HAMMING_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_cnt_clr
`endif
);

    syn_t syn;
    cw_t  cw_fix;
    logic err;
    logic in_xfer;

    logic out_valid_q, out_valid_d;
    cw_t  out_word_q,  out_word_d;
    logic out_err_q,   out_err_d;
    syn_t out_syn_q,   out_syn_d;

    hamming_syndrome u_syndrome (
        .cw_in  (in_word),
        .syn    (syn),
        .cw_fix (cw_fix),
        .err    (err)
    );

    // Register may reload whenever it is empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_err_d   = out_err_q;
        out_syn_d   = out_syn_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_word_d  = cw_fix;
            out_err_d   = err;
            out_syn_d   = syn;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_err_q   <= 1'b0;
            out_syn_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_err_q   <= out_err_d;
            out_syn_q   <= out_syn_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_err   = out_err_q;
    assign out_syn   = out_syn_q;

`ifdef HAMMING_ERR_COUNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Clear wins over a same-cycle increment; count sticks at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (in_xfer && err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    localparam int cnt_w_unused = CNT_W;
`endif

endmodule

// File: tb/tb_hamming_corrector.sv
// tb/tb_hamming_corrector.sv - directed self-checking bench for hamming_corrector
module tb_hamming_corrector;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_word;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_word;
    logic       out_err;
    logic [2:0] out_syn;
`ifdef HAMMING_ERR_COUNT_EN
    logic [7:0] err_cnt;
    logic       err_cnt_clr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_corrector #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_err   (out_err),
        .out_syn   (out_syn)
`ifdef HAMMING_ERR_COUNT_EN
        ,
        .err_cnt     (err_cnt),
        .err_cnt_clr (err_cnt_clr)
`endif
    );

    typedef struct {
        logic [6:0] in_w;
        logic [6:0] exp_w;
        logic       exp_err;
        logic [2:0] exp_syn;
    } vec_t;

    vec_t       vecs[$];
    logic [6:0] legal[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent encoder: data at bits 2,4,5,6, parity at bits 0,1,3.
    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] w;
        w    = '0;
        w[2] = d[0];
        w[4] = d[1];
        w[5] = d[2];
        w[6] = d[3];
        w[0] = w[2] ^ w[4] ^ w[6];
        w[1] = w[2] ^ w[5] ^ w[6];
        w[3] = w[4] ^ w[5] ^ w[6];
        return w;
    endfunction

    initial begin
        vec_t v;
        logic [6:0] a_w;
        logic [6:0] b_w;

        vecs.push_back('{7'b0101101, 7'b0101101, 1'b0, 3'd0});
        vecs.push_back('{7'b1101101, 7'b0101101, 1'b1, 3'd7});
        for (int i = 0; i < 7; i++) begin
            v.in_w    = 7'h7f ^ (7'd1 << i);
            v.exp_w   = 7'h7f;
            v.exp_err = 1'b1;
            v.exp_syn = 3'(i + 1);
            vecs.push_back(v);
        end
        vecs.push_back('{7'b0000000, 7'b0000000, 1'b0, 3'd0});
        vecs.push_back('{7'b0000111, 7'b0000111, 1'b0, 3'd0});
        vecs.push_back('{7'b0011001, 7'b0011001, 1'b0, 3'd0});
        vecs.push_back('{7'b0101010, 7'b0101010, 1'b0, 3'd0});
        vecs.push_back('{7'b1001011, 7'b1001011, 1'b0, 3'd0});
        vecs.push_back('{7'b1111111, 7'b1111111, 1'b0, 3'd0});
        // Double error on bits 0,1 of 0000000 miscorrects via bit 2.
        vecs.push_back('{7'b0000011, 7'b0000111, 1'b1, 3'd3});
        for (int i = 0; i < 16; i++) legal[i] = encode(4'(i));

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b1;
`ifdef HAMMING_ERR_COUNT_EN
        err_cnt_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_word",  32'(out_word),  32'd0);
        chk("reset out_err",   32'(out_err),   32'd0);
        chk("reset out_syn",   32'(out_syn),   32'd0);
        chk("reset in_ready",  32'(in_ready),  32'd1);
`ifdef HAMMING_ERR_COUNT_EN
        chk("reset err_cnt", 32'(err_cnt), 32'd0);
`endif

        foreach (vecs[k]) begin
            in_word  = vecs[k].in_w;
            in_valid = 1'b1;
            #1;
            chk("vec in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("vec out_valid", 32'(out_valid), 32'd1);
            chk("vec out_word",  32'(out_word),  32'(vecs[k].exp_w));
            chk("vec out_err",   32'(out_err),   32'(vecs[k].exp_err));
            chk("vec out_syn",   32'(out_syn),   32'(vecs[k].exp_syn));
            @(posedge clk);
            #1;
            chk("vec drained", 32'(out_valid), 32'd0);
        end

        in_word  = legal[0];
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            chk("b2b out_valid", 32'(out_valid), 32'd1);
            chk("b2b out_word",  32'(out_word),  32'(legal[i]));
            chk("b2b out_err",   32'(out_err),   32'd0);
            chk("b2b in_ready",  32'(in_ready),  32'd1);
            if (i < 15) in_word = legal[i + 1];
            else        in_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("b2b drained", 32'(out_valid), 32'd0);

        a_w      = legal[3];
        b_w      = legal[5];
        in_word  = a_w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("bp first word", 32'(out_word), 32'(a_w));
        in_word   = b_w;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp in_ready low", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            chk("bp out_valid held", 32'(out_valid), 32'd1);
            chk("bp out_word held",  32'(out_word),  32'(a_w));
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp second valid", 32'(out_valid), 32'd1);
        chk("bp second word",  32'(out_word),  32'(b_w));
        @(posedge clk);
        #1;
        chk("bp drained", 32'(out_valid), 32'd0);

`ifdef HAMMING_ERR_COUNT_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_word  = 7'b1101101;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (i == 9) chk("cnt after 10", 32'(err_cnt), 32'd10);
        end
        chk("cnt saturated", 32'(err_cnt), 32'd255);
        err_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        err_cnt_clr = 1'b0;
        chk("cnt clr priority", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        in_word = 7'b0101101;
        chk("cnt one more", 32'(err_cnt), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("cnt clean no inc", 32'(err_cnt), 32'd1);
        @(posedge clk);
        #1;
`endif

        in_word  = 7'b1101101;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("mid rst loaded", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst out_word",  32'(out_word),  32'd0);
        chk("mid rst out_err",   32'(out_err),   32'd0);
        chk("mid rst out_syn",   32'(out_syn),   32'd0);
        chk("mid rst in_ready",  32'(in_ready),  32'd1);
`ifdef HAMMING_ERR_COUNT_EN
        chk("mid rst err_cnt", 32'(err_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
